// File: rtl/timer_array_if.sv
// Register bus between a host and the timer array: word address, write strobe,
// write data, combinational read data and the registered interrupt line.
interface timer_array_if;
    logic [5:2]  addr;
    logic        we;
    logic [31:0] DEV_WD;
    logic [31:0] DEVTimer_RD;
    logic        IRQ;

    modport master (
        output addr,
        output we,
        output DEV_WD,
        input  DEVTimer_RD,
        input  IRQ
    );

    modport slave (
        input  addr,
        input  we,
        input  DEV_WD,
        output DEVTimer_RD,
        output IRQ
    );
endinterface

// File: rtl/timer_array.sv
// Array of NCH independent down-counting timers with per-channel prescaler,
// one-shot/periodic/hold modes, sticky pending flags and a shared registered IRQ.
module timer_array #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    timer_array_if.slave bus
);
    localparam int unsigned CW = 12;
    localparam int unsigned PW = 8;

    // CTRL layout: [0] EN, [2:1] MODE, [3] IM, [11:4] PRESC
    logic [CW-1:0]    ctrl_q   [NCH];
    logic [CW-1:0]    ctrl_d   [NCH];
    logic [WIDTH-1:0] preset_q [NCH];
    logic [WIDTH-1:0] preset_d [NCH];
    logic [WIDTH-1:0] count_q  [NCH];
    logic [WIDTH-1:0] count_d  [NCH];
    logic [PW-1:0]    psc_q    [NCH];
    logic [PW-1:0]    psc_d    [NCH];
    logic             pend_q   [NCH];
    logic             pend_d   [NCH];
    logic             irq_q;
    logic             irq_d;

    logic [1:0]       ch;
    logic [1:0]       sel;
    logic [WIDTH-1:0] wdw;
    logic             wr_c;
    logic             tick_c;
    logic             set_c;
    logic             clr_c;
    logic [31:0]      rd_c;

    assign ch  = bus.addr[5:4];
    assign sel = bus.addr[3:2];
    assign wdw = bus.DEV_WD[WIDTH-1:0];

    // Next-state for every channel; bus writes override the tick update of COUNT.
    always_comb begin
        irq_d  = 1'b0;
        wr_c   = 1'b0;
        tick_c = 1'b0;
        set_c  = 1'b0;
        clr_c  = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            ctrl_d[i]   = ctrl_q[i];
            preset_d[i] = preset_q[i];
            count_d[i]  = count_q[i];
            wr_c        = bus.we && (32'(ch) == i);
            tick_c      = ctrl_q[i][0] && (psc_q[i] == ctrl_q[i][11:4]);
            set_c       = 1'b0;
            clr_c       = 1'b0;
            psc_d[i]    = (tick_c || !ctrl_q[i][0]) ? '0 : psc_q[i] + PW'(1);

            // MODE[1] set means hold: COUNT frozen and no events
            if (tick_c && !ctrl_q[i][2]) begin
                if (count_q[i] > WIDTH'(1)) begin
                    count_d[i] = count_q[i] - WIDTH'(1);
                end else if (count_q[i] == WIDTH'(1)) begin
                    set_c      = 1'b1;
                    count_d[i] = ctrl_q[i][1] ? preset_q[i] : '0;
                end else if (ctrl_q[i][1]) begin
                    count_d[i] = preset_q[i];
                end
            end

            if (wr_c) begin
                case (sel)
                    2'd0: begin
                        ctrl_d[i] = bus.DEV_WD[CW-1:0];
                        psc_d[i]  = '0;
                    end
                    2'd1: begin
                        preset_d[i] = wdw;
                        count_d[i]  = wdw;
                    end
                    2'd2:    count_d[i] = wdw;
                    default: clr_c = bus.DEV_WD[0];
                endcase
            end

            pend_d[i] = set_c | (pend_q[i] & ~clr_c);
            irq_d     = irq_d | (pend_q[i] & ctrl_q[i][3]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '{default: '0};
            preset_q <= '{default: '0};
            count_q  <= '{default: '0};
            psc_q    <= '{default: '0};
            pend_q   <= '{default: '0};
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            psc_q    <= psc_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
        end
    end

    // Read mux; unimplemented channels fall through to zero.
    always_comb begin
        rd_c = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (32'(ch) == i) begin
                case (sel)
                    2'd0:    rd_c = 32'(ctrl_q[i]);
                    2'd1:    rd_c = 32'(preset_q[i]);
                    2'd2:    rd_c = 32'(count_q[i]);
                    default: rd_c = 32'(pend_q[i]);
                endcase
            end
        end
    end

    assign bus.DEVTimer_RD = rd_c;
    assign bus.IRQ         = irq_q;
endmodule

// File: tb/tb_timer_array.sv
// Randomized bench for timer_array against a cycle-level behavioural model,
// plus directed one-shot, periodic, reset and 8-bit-width scenarios.
module tb_timer_array;
    localparam int unsigned NCH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    timer_array_if bus ();
    timer_array_if bus8 ();

    timer_array #(.NCH(NCH), .WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    timer_array #(.NCH(1), .WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    logic [11:0] m_ctrl   [NCH];
    logic [31:0] m_preset [NCH];
    logic [31:0] m_count  [NCH];
    logic [7:0]  m_psc    [NCH];
    logic        m_pend   [NCH];
    logic        m_irq;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    task automatic m_reset();
        for (int c = 0; c < int'(NCH); c++) begin
            m_ctrl[c] = '0; m_preset[c] = '0; m_count[c] = '0;
            m_psc[c] = '0; m_pend[c] = 1'b0;
        end
        m_irq = 1'b0;
    endtask

    // a = {channel, register select}
    function automatic logic [31:0] m_read(input logic [3:0] a);
        int unsigned c;
        c = 32'(a[3:2]);
        if (c >= NCH) return 32'd0;
        case (a[1:0])
            2'd0:    return {20'd0, m_ctrl[c]};
            2'd1:    return m_preset[c];
            2'd2:    return m_count[c];
            default: return {31'd0, m_pend[c]};
        endcase
    endfunction

    // One clock edge of the reference: events from the pre-edge state, then the bus write.
    task automatic m_step(input logic we, input logic [3:0] a, input logic [31:0] wd);
        logic nirq;
        nirq = 1'b0;
        for (int c = 0; c < int'(NCH); c++) nirq |= m_pend[c] & m_ctrl[c][3];
        for (int c = 0; c < int'(NCH); c++) begin
            logic        en, tick, fire, clear;
            logic [1:0]  mode;
            logic [31:0] cnt;
            logic [7:0]  psc;
            en   = m_ctrl[c][0];
            mode = m_ctrl[c][2:1];
            tick = en && (m_psc[c] == m_ctrl[c][11:4]);
            psc  = (!en || tick) ? 8'd0 : m_psc[c] + 8'd1;
            cnt  = m_count[c];
            fire = 1'b0;
            clear = 1'b0;
            if (tick && mode == 2'b00) begin
                if (cnt > 1) cnt = cnt - 1;
                else if (cnt == 1) begin cnt = 0; fire = 1'b1; end
            end else if (tick && mode == 2'b01) begin
                if (cnt > 1) cnt = cnt - 1;
                else begin fire = (cnt == 1); cnt = m_preset[c]; end
            end
            if (we && int'(a[3:2]) == c) begin
                case (a[1:0])
                    2'd0: begin m_ctrl[c] = wd[11:0]; psc = 8'd0; end
                    2'd1: begin m_preset[c] = wd; cnt = wd; end
                    2'd2: cnt = wd;
                    default: clear = wd[0];
                endcase
            end
            m_count[c] = cnt;
            m_psc[c]   = psc;
            m_pend[c]  = fire || (m_pend[c] && !clear);
        end
        m_irq = nirq;
    endtask

    task automatic bus_cycle(input logic we, input logic [3:0] a, input logic [31:0] wd);
        bus.we = we; bus.addr = a; bus.DEV_WD = wd;
        @(posedge clk);
        m_step(we, a, wd);
        #1;
        check_eq("rd", bus.DEVTimer_RD, m_read(a));
        check_eq("irq", 32'(bus.IRQ), 32'(m_irq));
    endtask

    task automatic reset_reads(input string tag);
        bus.we = 1'b0;
        for (int a = 0; a < 16; a++) begin
            bus.addr = 4'(a);
            #1;
            check_eq(tag, bus.DEVTimer_RD, 32'd0);
        end
        check_eq("rst_irq", 32'(bus.IRQ), 32'd0);
    endtask

    logic [31:0] os_cnt [4] = '{32'd2, 32'd1, 32'd0, 32'd0};
    logic [31:0] os_irq [4] = '{32'd0, 32'd0, 32'd0, 32'd1};

    initial begin
        logic [3:0]  a;
        logic [31:0] wd;
        logic        we;
        rst = 1'b1;
        bus.we = 1'b0; bus.addr = '0; bus.DEV_WD = '0;
        bus8.we = 1'b0; bus8.addr = '0; bus8.DEV_WD = '0;
        m_reset();
        #2;
        reset_reads("rst_rd");
        @(negedge clk) rst = 1'b0;

        // 8-bit instance: PRESET truncates, one-shot counts down from 0xFF
        @(negedge clk);
        bus8.we = 1'b1; bus8.addr = 4'b0001; bus8.DEV_WD = 32'h1FF;
        @(posedge clk); #1;
        check_eq("w8_preset", bus8.DEVTimer_RD, 32'h0000_00FF);
        bus8.addr = 4'b0000; bus8.DEV_WD = 32'hFFFF_F009;
        @(posedge clk); #1;
        check_eq("w8_ctrl", bus8.DEVTimer_RD, 32'h0000_0009);
        bus8.we = 1'b0; bus8.addr = 4'b0010;
        @(posedge clk); #1;
        check_eq("w8_cnt0", bus8.DEVTimer_RD, 32'h0000_00FE);
        @(posedge clk); #1;
        check_eq("w8_cnt1", bus8.DEVTimer_RD, 32'h0000_00FD);
        bus8.addr = 4'b0110; #1;
        check_eq("w8_ch1", bus8.DEVTimer_RD, 32'd0);

        // One-shot on channel 0
        bus_cycle(1'b1, 4'b0001, 32'd3);
        check_eq("os_preset", bus.DEVTimer_RD, 32'd3);
        bus_cycle(1'b1, 4'b0000, 32'h9);
        for (int k = 0; k < 4; k++) begin
            bus_cycle(1'b0, 4'b0010, 32'd0);
            check_eq("os_cnt", bus.DEVTimer_RD, os_cnt[k]);
            check_eq("os_irq", 32'(bus.IRQ), os_irq[k]);
        end
        bus_cycle(1'b0, 4'b0011, 32'd0);
        check_eq("os_pend", bus.DEVTimer_RD, 32'd1);
        bus_cycle(1'b1, 4'b0011, 32'd1);
        bus_cycle(1'b1, 4'b0000, 32'd0);

        // Periodic on channel 1, W1C racing a reload
        bus_cycle(1'b1, 4'b0101, 32'd2);
        bus_cycle(1'b1, 4'b0100, 32'hB);
        for (int k = 0; k < 6; k++) bus_cycle(1'b0, 4'b0110, 32'd0);
        for (int k = 0; k < 4 && m_count[1] != 32'd1; k++) bus_cycle(1'b0, 4'b0111, 32'd0);
        bus_cycle(1'b1, 4'b0111, 32'd1);
        check_eq("w1c_set_wins", bus.DEVTimer_RD, 32'd1);
        bus_cycle(1'b1, 4'b0111, 32'd1);
        check_eq("w1c_clear", bus.DEVTimer_RD, 32'd0);
        bus_cycle(1'b1, 4'b0100, 32'd0);
        bus_cycle(1'b1, 4'b0111, 32'd1);

        // Out-of-range channel and COUNT write racing a tick
        bus_cycle(1'b1, 4'b1100, 32'hF);
        check_eq("ch3_rd", bus.DEVTimer_RD, 32'd0);
        bus_cycle(1'b1, 4'b0010, 32'd9);
        bus_cycle(1'b1, 4'b0000, 32'h1);
        bus_cycle(1'b0, 4'b0010, 32'd0);
        bus_cycle(1'b1, 4'b0010, 32'd5);
        check_eq("cnt_wr_prio", bus.DEVTimer_RD, 32'd5);

        for (int it = 0; it < 1500; it++) begin
            if (it == 700) begin
                #1 rst = 1'b1;
                m_reset();
                #1;
                reset_reads("rst_mid");
                @(negedge clk) rst = 1'b0;
            end
            a  = 4'($urandom);
            we = ($urandom_range(0, 5) == 0);
            case (a[1:0])
                2'd0:    wd = ($urandom & 32'hFFFF_F00F) | (32'($urandom_range(0, 3)) << 4);
                2'd1,
                2'd2:    wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 6));
                default: wd = $urandom;
            endcase
            bus_cycle(we, a, wd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/timer_array.md
TIMER_ARRAY -- requirements
Module: timer_array

Interface
REQ-001 Parameter NCH, default 2, number of independent timer channels, legal range 1..4.
REQ-002 Parameter WIDTH, default 32, counter/preset width in bits, legal range 8..32.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 addr  input  [5:2]  word address; addr[5:4] = channel index, addr[3:2] = register select.
REQ-006 we  input  1  write strobe, sampled on rising clk.
REQ-007 DEV_WD  input  32  write data.
REQ-008 DEVTimer_RD  output  32  read data, combinational from addr.
REQ-009 IRQ  output  1  registered interrupt request, OR of all enabled channel interrupts.

Function
REQ-010 Each channel SHALL hold CTRL, PRESET, COUNT and STATUS registers at register select 0, 1, 2, 3 respectively.
REQ-011 CTRL fields SHALL be: [0] EN, [2:1] MODE, [3] IM, [11:4] PRESC; bits [31:12] SHALL read 0 and ignore writes.
REQ-012 MODE SHALL decode: 00 one-shot, 01 periodic, 10/11 hold (COUNT frozen, no events).
REQ-013 PRESET and COUNT SHALL be WIDTH bits, zero-extended on read, DEV_WD[WIDTH-1:0] used on write.
REQ-014 STATUS SHALL be bit 0 PEND, bits [31:1] read 0; writing 1 to bit 0 clears PEND; writing 0 has no effect.
REQ-015 Reads/writes to channel index >= NCH SHALL return 0 and be ignored.
REQ-016 Each channel SHALL contain an 8-bit prescale counter; while EN=1 it SHALL produce a one-cycle tick every PRESC+1 clocks (PRESC=0: tick every clock).
REQ-017 Prescale counter SHALL clear to 0 on any CTRL write and hold at 0 while EN=0.
REQ-018 On a tick with COUNT > 1: COUNT <= COUNT-1.
REQ-019 On a tick with COUNT == 1, one-shot: COUNT <= 0, PEND <= 1; subsequent ticks with COUNT == 0 SHALL do nothing.
REQ-020 On a tick with COUNT == 1, periodic: COUNT <= PRESET, PEND <= 1 (reload on the same edge, period = PRESET ticks).
REQ-021 On a tick with COUNT == 0, periodic: COUNT <= PRESET, no PEND; PRESET == 0 leaves the channel idle.
REQ-022 Writing PRESET SHALL also load COUNT with the written value on the same edge.
REQ-023 Writing COUNT SHALL load COUNT directly; PRESET unchanged.
REQ-024 A bus write to PRESET or COUNT SHALL take priority over a same-cycle tick update of COUNT for that channel.
REQ-025 A same-cycle PEND set and STATUS W1C SHALL leave PEND = 1 (set wins).
REQ-026 PEND SHALL be set regardless of IM; IM only gates IRQ.
REQ-027 IRQ SHALL be registered: IRQ <= OR over channels of (PEND & IM), one clock after the contributing PEND/IM change.
REQ-028 Channels SHALL operate fully independently; simultaneous events on several channels SHALL all be recorded.
REQ-029 COUNT arithmetic SHALL never wrap below 0.

Reset
REQ-030 While rst=1, all CTRL, PRESET, COUNT, PEND, prescale counters and IRQ SHALL be 0, asynchronously, regardless of clk.
REQ-031 Reset asserted mid-count SHALL abort all channels; after release no channel runs until CTRL EN is written 1.
REQ-032 DEVTimer_RD after reset SHALL read 0 for every implemented address.

Verification
REQ-033 Ch0 PRESET=3, CTRL=0x9 (one-shot, EN, IM, PRESC=0) -> COUNT 3,2,1,0 on successive clocks, PEND=1 at 3rd tick, IRQ=1 one clock later, COUNT stays 0.
REQ-034 Ch1 PRESET=2, CTRL=0xB (periodic, IM) -> COUNT 2,1,2,1..., PEND set every 2 ticks; STATUS write 1 clears PEND and IRQ drops next clock; W1C coinciding with reload leaves PEND=1.
REQ-035 Ch0 PRESET=2, CTRL PRESC=3, EN -> COUNT decrements once every 4 clocks; CTRL rewrite mid-period restarts the 4-clock spacing.
REQ-036 IM=0 with expiry -> PEND=1, IRQ=0; then set IM=1 -> IRQ=1 one clock later; write to channel 3 with NCH=2 -> no state change, read returns 0.
REQ-037 COUNT write of 5 coinciding with a tick -> COUNT reads 5 next cycle; rst pulsed mid-count -> all registers and IRQ 0 immediately, no counting after release.
REQ-038 Repeat REQ-033 with WIDTH=8, PRESET=0x1FF written -> PRESET reads 0xFF, upper bits 0.
